// File: rtl/gpu_cmd_master.sv
// gpu_cmd_master: queues host command/data pairs and issues them to gpu_core over stb/ack,
// collecting read results in a response FIFO and aborting transactions that never ack.
module gpu_cmd_master #(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_command,
    input  logic [63:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [31:0] gpu_command,
    output logic [63:0] gpu_data_in,
    input  logic [63:0] gpu_data_out,
    output logic        gpu_stb,
    input  logic        gpu_ack,
    output logic        busy,
    output logic        timeout_err,
    input  logic        clr_err
);
    localparam int RW = $clog2(REQ_DEPTH);
    localparam int SW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state, state_n;

    logic [31:0]   req_cmd_mem [REQ_DEPTH];
    logic [63:0]   req_dat_mem [REQ_DEPTH];
    logic [RW-1:0] req_wr, req_rd;
    logic [RW:0]   req_cnt;
    logic [63:0]   rsp_mem [RSP_DEPTH];
    logic [SW-1:0] rsp_wr, rsp_rd;
    logic [SW:0]   rsp_cnt;
    logic [CW-1:0] tmo_cnt;
    logic          req_push, req_pop, rsp_push, rsp_pop;
    logic          head_read, rsp_blocked, acked, expired;

    assign req_ready   = req_cnt != (RW+1)'(REQ_DEPTH);
    assign req_push    = req_valid && req_ready;
    assign rsp_valid   = rsp_cnt != '0;
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign rsp_data    = rsp_mem[rsp_rd];
    assign head_read   = req_cmd_mem[req_rd][15:12] == 4'b0000;
    // A read may only start once its result is guaranteed a slot; a same-cycle pop frees one.
    assign rsp_blocked = head_read && rsp_cnt == (SW+1)'(RSP_DEPTH) && !rsp_pop;
    assign acked       = state == ISSUE && gpu_ack;
    assign expired     = state == ISSUE && !gpu_ack && tmo_cnt == CW'(TIMEOUT - 1);
    assign rsp_push    = acked && gpu_command[15:12] == 4'b0000;
    assign busy        = req_cnt != '0 || state != IDLE;

    // GAP can issue directly so back-to-back commands see a single stb-low cycle.
    always_comb begin
        req_pop = state != ISSUE && req_cnt != '0 && !rsp_blocked;
        state_n = req_pop ? ISSUE :
                  state == ISSUE ? ((acked || expired) ? GAP : ISSUE) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_wr      <= '0;
            req_rd      <= '0;
            req_cnt     <= '0;
            rsp_wr      <= '0;
            rsp_rd      <= '0;
            rsp_cnt     <= '0;
            tmo_cnt     <= '0;
            gpu_stb     <= 1'b0;
            gpu_command <= '0;
            gpu_data_in <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (req_push) begin
                req_cmd_mem[req_wr] <= req_command;
                req_dat_mem[req_wr] <= req_data;
                req_wr              <= req_wr + 1'b1;
            end
            if (req_pop) begin
                gpu_command <= req_cmd_mem[req_rd];
                gpu_data_in <= req_dat_mem[req_rd];
                req_rd      <= req_rd + 1'b1;
            end
            req_cnt <= req_cnt + (RW+1)'(req_push) - (RW+1)'(req_pop);
            if (rsp_push) begin
                rsp_mem[rsp_wr] <= gpu_data_out;
                rsp_wr          <= rsp_wr + 1'b1;
            end
            if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;
            rsp_cnt     <= rsp_cnt + (SW+1)'(rsp_push) - (SW+1)'(rsp_pop);
            tmo_cnt     <= state == ISSUE ? tmo_cnt + 1'b1 : '0;
            gpu_stb     <= state_n == ISSUE;
            timeout_err <= expired || (timeout_err && !clr_err);
        end
    end
endmodule
